register_file: RTL and testbench

- Architectural register file with per-register rename tags, sitting directly downstream of the reorder buffer.
- Consumes the ROB's issue stream (new destination tag) and commit stream (architectural write-back).
- Consumes the ROB's registered clear (misprediction flush).
- Answers the decoder's rs1/rs2 operand queries with value or producing ROB tag.

---
 rtl/register_file.sv | 100 ++++++++++
 tb/tb_register_file.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural register file with rename tags, fed by the ROB issue/commit streams.
// Answers two decoder operand queries combinationally with either a value or a producer tag.
module register_file #(
    parameter int REG_NUM  = 32,
    parameter int REG_ADDR = 5,
    parameter int ROB_ADDR = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear,
    input  logic                rf_issue,
    input  logic [REG_ADDR-1:0] rf_issue_rd,
    input  logic [ROB_ADDR-1:0] rf_new_dep,
    input  logic                rf_commit,
    input  logic [REG_ADDR-1:0] rf_commit_rd,
    input  logic [ROB_ADDR-1:0] rf_robid,
    input  logic [31:0]         rf_value,
    input  logic [REG_ADDR-1:0] dc_rs1,
    input  logic [REG_ADDR-1:0] dc_rs2,
    output logic                rs1_busy,
    output logic [ROB_ADDR-1:0] rs1_dep,
    output logic [31:0]         rs1_value,
    output logic                rs2_busy,
    output logic [ROB_ADDR-1:0] rs2_dep,
    output logic [31:0]         rs2_value
);

    logic [31:0]         value [REG_NUM];
    logic                busy  [REG_NUM];
    logic [ROB_ADDR-1:0] dep   [REG_NUM];

    logic commit_wr;
    logic issue_wr;

    assign commit_wr = rf_commit && (rf_commit_rd != '0);
    assign issue_wr  = rf_issue && (rf_issue_rd != '0) && !clear;

    // Issue is applied after commit so a same-register issue overrides the commit's busy release.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value[i] <= '0;
                busy[i]  <= 1'b0;
                dep[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (commit_wr) begin
                value[rf_commit_rd] <= rf_value;
                if (dep[rf_commit_rd] == rf_robid)
                    busy[rf_commit_rd] <= 1'b0;
            end
            if (clear) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    busy[i] <= 1'b0;
                    dep[i]  <= '0;
                end
            end else if (issue_wr) begin
                busy[rf_issue_rd] <= 1'b1;
                dep[rf_issue_rd]  <= rf_new_dep;
            end
        end
    end

    // A commit retiring the current producer is forwarded so the decoder need not wait a cycle.
    always_comb begin
        rs1_busy  = 1'b0;
        rs1_dep   = '0;
        rs1_value = '0;
        if (dc_rs1 != '0) begin
            if (rdy_in && rf_commit && (rf_commit_rd == dc_rs1) && busy[dc_rs1]
                && (dep[dc_rs1] == rf_robid)) begin
                rs1_value = rf_value;
            end else if (busy[dc_rs1]) begin
                rs1_busy = 1'b1;
                rs1_dep  = dep[dc_rs1];
            end else begin
                rs1_value = value[dc_rs1];
            end
        end
    end

    always_comb begin
        rs2_busy  = 1'b0;
        rs2_dep   = '0;
        rs2_value = '0;
        if (dc_rs2 != '0) begin
            if (rdy_in && rf_commit && (rf_commit_rd == dc_rs2) && busy[dc_rs2]
                && (dep[dc_rs2] == rf_robid)) begin
                rs2_value = rf_value;
            end else if (busy[dc_rs2]) begin
                rs2_busy = 1'b1;
                rs2_dep  = dep[dc_rs2];
            end else begin
                rs2_value = value[dc_rs2];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed scoreboard bench for register_file: stimulus pushes expected query results,
// a negedge monitor pops and compares them against the live combinational outputs.
module tb_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        rf_issue;
    logic [4:0]  rf_issue_rd;
    logic [3:0]  rf_new_dep;
    logic        rf_commit;
    logic [4:0]  rf_commit_rd;
    logic [3:0]  rf_robid;
    logic [31:0] rf_value;
    logic [4:0]  dc_rs1;
    logic [4:0]  dc_rs2;
    logic        rs1_busy;
    logic [3:0]  rs1_dep;
    logic [31:0] rs1_value;
    logic        rs2_busy;
    logic [3:0]  rs2_dep;
    logic [31:0] rs2_value;

    typedef struct {
        string       name;
        logic        b1;
        logic [3:0]  d1;
        logic [31:0] v1;
        logic        b2;
        logic [3:0]  d2;
        logic [31:0] v2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    register_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .rf_issue(rf_issue), .rf_issue_rd(rf_issue_rd), .rf_new_dep(rf_new_dep),
        .rf_commit(rf_commit), .rf_commit_rd(rf_commit_rd), .rf_robid(rf_robid),
        .rf_value(rf_value), .dc_rs1(dc_rs1), .dc_rs2(dc_rs2),
        .rs1_busy(rs1_busy), .rs1_dep(rs1_dep), .rs1_value(rs1_value),
        .rs2_busy(rs2_busy), .rs2_dep(rs2_dep), .rs2_value(rs2_value)
    );

    always #5 clk_in = ~clk_in;

    // Drives one cycle of inputs just after the rising edge; state updates on the next edge.
    task automatic applyStimulus(input logic rst, input logic rdy, input logic clr,
                                 input logic iss, input logic [4:0] iss_rd, input logic [3:0] iss_dep,
                                 input logic com, input logic [4:0] com_rd, input logic [3:0] robid,
                                 input logic [31:0] val, input logic [4:0] rs1, input logic [4:0] rs2);
        @(posedge clk_in);
        #1;
        rst_in       = rst;
        rdy_in       = rdy;
        clear        = clr;
        rf_issue     = iss;
        rf_issue_rd  = iss_rd;
        rf_new_dep   = iss_dep;
        rf_commit    = com;
        rf_commit_rd = com_rd;
        rf_robid     = robid;
        rf_value     = val;
        dc_rs1       = rs1;
        dc_rs2       = rs2;
    endtask

    task automatic checkOutput(input string name,
                               input logic b1, input logic [3:0] d1, input logic [31:0] v1,
                               input logic b2, input logic [3:0] d2, input logic [31:0] v2);
        exp_t e;
        e.name = name;
        e.b1 = b1; e.d1 = d1; e.v1 = v1;
        e.b2 = b2; e.d2 = d2; e.v2 = v2;
        exp_q.push_back(e);
    endtask

    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({rs1_busy, rs1_dep, rs1_value} !== {e.b1, e.d1, e.v1}) begin
                errors++;
                $display("[TB] FAIL %s rs1: got busy=%0b dep=%0d value=%h, expected busy=%0b dep=%0d value=%h",
                         e.name, rs1_busy, rs1_dep, rs1_value, e.b1, e.d1, e.v1);
            end
            checks++;
            if ({rs2_busy, rs2_dep, rs2_value} !== {e.b2, e.d2, e.v2}) begin
                errors++;
                $display("[TB] FAIL %s rs2: got busy=%0b dep=%0d value=%h, expected busy=%0b dep=%0d value=%h",
                         e.name, rs2_busy, rs2_dep, rs2_value, e.b2, e.d2, e.v2);
            end
        end
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
        rf_issue = 1'b0; rf_issue_rd = '0; rf_new_dep = '0;
        rf_commit = 1'b0; rf_commit_rd = '0; rf_robid = '0; rf_value = '0;
        dc_rs1 = '0; dc_rs2 = '0;

        // Reset and x0 behaviour
        applyStimulus(0,1,0, 0,0,0, 0,0,0,0, 0,0);
        applyStimulus(0,1,0, 0,0,0, 0,0,0,0, 0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 3,0);
        checkOutput("reset_q", 0,0,0, 0,0,0);
        applyStimulus(1,1,0, 1,0,5, 0,0,0,0, 0,0);
        checkOutput("x0_issue_same", 0,0,0, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 0,3);
        checkOutput("x0_after_issue", 0,0,0, 0,0,0);

        // Issue, then commit bypass
        applyStimulus(1,1,0, 1,5,2, 0,0,0,0, 5,0);
        checkOutput("issue_not_visible", 0,0,0, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 5,5);
        checkOutput("x5_busy", 1,2,0, 1,2,0);
        applyStimulus(1,1,0, 0,0,0, 1,5,2,32'h1234, 5,7);
        checkOutput("x5_bypass", 0,0,32'h1234, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 5,0);
        checkOutput("x5_committed", 0,0,32'h1234, 0,0,0);

        // Younger producer keeps ownership
        applyStimulus(1,1,0, 1,7,1, 0,0,0,0, 7,0);
        checkOutput("x7_pre", 0,0,0, 0,0,0);
        applyStimulus(1,1,0, 1,7,3, 0,0,0,0, 7,0);
        checkOutput("x7_dep1", 1,1,0, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 1,7,1,32'hAA, 7,0);
        checkOutput("x7_stale_commit", 1,3,0, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 7,0);
        checkOutput("x7_still_busy", 1,3,0, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 1,7,3,32'hBB, 7,0);
        checkOutput("x7_bypass", 0,0,32'hBB, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 7,0);
        checkOutput("x7_done", 0,0,32'hBB, 0,0,0);

        // Same-cycle commit and issue to x9
        applyStimulus(1,1,0, 1,9,4, 0,0,0,0, 9,0);
        checkOutput("x9_pre", 0,0,0, 0,0,0);
        applyStimulus(1,1,0, 1,9,6, 1,9,4,32'h55, 9,0);
        checkOutput("x9_bypass", 0,0,32'h55, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 9,0);
        checkOutput("x9_reissued", 1,6,0, 0,0,0);
        applyStimulus(1,1,1, 0,0,0, 0,0,0,0, 9,0);
        checkOutput("x9_during_clear", 1,6,0, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 9,0);
        checkOutput("x9_after_clear", 0,0,32'h55, 0,0,0);

        // Flush with concurrent issue (dropped) and commit (kept)
        applyStimulus(1,1,0, 1,1,1, 1,2,0,32'h10, 0,0);
        applyStimulus(1,1,0, 1,2,2, 0,0,0,0, 0,0);
        applyStimulus(1,1,0, 1,3,3, 0,0,0,0, 1,2);
        checkOutput("x1_x2_busy", 1,1,0, 1,2,0);
        applyStimulus(1,1,1, 1,4,8, 1,6,0,32'h66, 3,4);
        checkOutput("x3_busy_at_clear", 1,3,0, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 2,4);
        checkOutput("x2_x4_after_clear", 0,0,32'h10, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 1,3);
        checkOutput("x1_x3_after_clear", 0,0,0, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 6,4);
        checkOutput("x6_commit_in_clear", 0,0,32'h66, 0,0,0);

        // rdy_in low freezes state and disables the bypass
        applyStimulus(1,1,0, 1,10,5, 0,0,0,0, 0,0);
        applyStimulus(1,0,1, 1,11,7, 1,10,5,32'h99, 10,11);
        checkOutput("stall_no_bypass", 1,5,0, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 10,11);
        checkOutput("stall_held", 1,5,0, 0,0,0);

        // Mid-stream reset
        applyStimulus(0,1,0, 1,13,1, 0,0,0,0, 10,5);
        checkOutput("pre_reset", 1,5,0, 0,0,32'h1234);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 10,5);
        checkOutput("post_reset_a", 0,0,0, 0,0,0);
        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 13,7);
        checkOutput("post_reset_b", 0,0,0, 0,0,0);

        applyStimulus(1,1,0, 0,0,0, 0,0,0,0, 0,0);
        @(posedge clk_in);
        @(posedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
